// File: rtl/collatz_sweep_if.sv
// Handshake bundle between the sweep controller and the tests_collatz stage.
//   out_valid/out_ready/out0 : seed requests (controller -> stage in0)
//   in_valid/in_ready/in0    : results (stage out0 -> controller)
// master modport is the controller side, slave modport is the stage side.
interface collatz_sweep_if #(
    parameter int unsigned WIDTH = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out0;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;

    modport master (
        output out_valid,
        output out0,
        output in_ready,
        input  out_ready,
        input  in_valid,
        input  in0
    );

    modport slave (
        input  out_valid,
        input  out0,
        input  in_ready,
        output out_ready,
        output in_valid,
        output in0
    );
endinterface

// File: rtl/collatz_sweep.sv
// Sweep controller for the tests_collatz stage: issues seeds seed_lo..seed_hi,
// pairs each in-order result with its seed through a small FIFO, and tracks
// the largest result, its seed and the number of results consumed.
// Ports:
//   clk, nrst          clock, synchronous active-low reset
//   start              begin sweep (honoured only when idle/done)
//   seed_lo, seed_hi   inclusive unsigned seed range, latched on start
//   busy, done         sweep in progress / sweep finished
//   bus (master)       seed request and result handshakes
//   best_seed          seed that produced best_result
//   best_result        largest result seen this sweep
//   count              results consumed this sweep
module collatz_sweep #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic [WIDTH-1:0]   seed_lo,
    input  logic [WIDTH-1:0]   seed_hi,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   best_seed,
    output logic [WIDTH-1:0]   best_result,
    output logic [WIDTH:0]     count,
    collatz_sweep_if.master    bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]    OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]    OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [WIDTH:0] W1_ONE   = (WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   next_seed;   // one bit wider so seed_hi = all-ones ends cleanly
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      occ;
    logic             full, empty, last_seed;
    logic             out_v, in_r, load, push, pop;

    assign full      = (occ == OCC_FULL);
    assign empty     = (occ == '0);
    assign last_seed = (next_seed == {1'b0, hi_q});
    assign push      = out_v && bus.out_ready;
    assign pop       = in_r && bus.in_valid;

    assign bus.out_valid = out_v;
    assign bus.in_ready  = in_r;
    assign bus.out0      = next_seed[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        out_v     = 1'b0;
        in_r      = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    load      = 1'b1;
                    state_nxt = (seed_lo <= seed_hi) ? RUN : DONE;
                end
            end
            RUN: begin
                busy  = 1'b1;
                out_v = !full;
                in_r  = !empty;
                if (out_v && bus.out_ready && last_seed) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                in_r = !empty;
                // No pushes happen in DRAIN, so popping the last entry empties the FIFO.
                if (in_r && bus.in_valid && occ == OCC_ONE) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Seed storage carries no reset; occupancy and pointers define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= next_seed[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            next_seed   <= '0;
            hi_q        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            best_seed   <= '0;
            best_result <= '0;
            count       <= '0;
        end else begin
            if (load) begin
                next_seed   <= {1'b0, seed_lo};
                hi_q        <= seed_hi;
                best_seed   <= '0;
                best_result <= '0;
                count       <= '0;
            end
            if (push) begin
                wr_ptr    <= wr_ptr + PTR_ONE;
                next_seed <= next_seed + W1_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                count  <= count + W1_ONE;
                // Strict compare: ties keep the earliest seed.
                if (count == '0 || bus.in0 > best_result) begin
                    best_result <= bus.in0;
                    best_seed   <= mem[rd_ptr];
                end
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_collatz_sweep.sv
// Self-checking bench for collatz_sweep: a behavioural tests_collatz responder
// (random accept, random 1-5 cycle latency, in-order results) plus a reference
// computed directly from the seed range.
module tb_collatz_sweep;
    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [15:0] seed_lo, seed_hi;
    logic        busy, done;
    logic [15:0] best_seed, best_result;
    logic [16:0] count;

    collatz_sweep_if #(.WIDTH(16)) bus ();

    collatz_sweep #(.WIDTH(16), .DEPTH(4)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .seed_lo     (seed_lo),
        .seed_hi     (seed_hi),
        .busy        (busy),
        .done        (done),
        .best_seed   (best_seed),
        .best_result (best_result),
        .count       (count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // responder controls
    logic hold       = 1'b0;
    logic const_mode = 1'b0;
    logic rdy_rand   = 1'b0;

    int exp_seed = 0;
    int n_push   = 0;
    int cyc      = 0;
    int pend_seed[$];
    int pend_due[$];
    logic        f_push = 1'b0, f_pop = 1'b0;
    logic [15:0] f_seed = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_result(input logic [15:0] s);
        longint unsigned v;
        int unsigned     n;
        if (const_mode) return 16'd5;
        v = 64'(s);
        n = 0;
        while (v > 1) begin
            v = (v % 2 == 0) ? v / 2 : 3 * v + 1;
            n++;
        end
        return 16'(n);
    endfunction

    // tests_collatz stand-in; inputs driven 1 time unit after each edge,
    // handshakes decided there are committed after the following edge.
    initial begin
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in0       = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!nrst) begin
                pend_seed.delete();
                pend_due.delete();
            end else begin
                if (f_push) begin
                    check("seed_order", 32'(f_seed), 32'(exp_seed));
                    exp_seed++;
                    n_push++;
                    pend_seed.push_back(int'(f_seed));
                    pend_due.push_back(cyc + int'($urandom_range(0, 4)));
                end
                if (f_pop) begin
                    void'(pend_seed.pop_front());
                    void'(pend_due.pop_front());
                end
            end
            bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (nrst && !hold && pend_seed.size() > 0 && pend_due[0] <= cyc) begin
                bus.in_valid = 1'b1;
                bus.in0      = ref_result(16'(pend_seed[0]));
            end else begin
                bus.in_valid = 1'b0;
                bus.in0      = 16'($urandom);
            end
            f_push = bus.out_valid && bus.out_ready;
            f_seed = bus.out0;
            f_pop  = bus.in_valid && bus.in_ready;
        end
    end

    task automatic start_sweep(input int lo, input int hi);
        @(negedge clk);
        seed_lo  = 16'(lo);
        seed_hi  = 16'(hi);
        start    = 1'b1;
        exp_seed = lo;
        n_push   = 0;
        @(negedge clk);
        start   = 1'b0;
        seed_lo = 16'($urandom);
        seed_hi = 16'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic check_result(input string tag, input int lo, input int hi);
        int unsigned ecount = 0;
        logic [15:0] eb_seed = '0, eb_res = '0, r;
        for (int s = lo; s <= hi; s++) begin
            r = ref_result(16'(s));
            if (ecount == 0 || r > eb_res) begin
                eb_res  = r;
                eb_seed = 16'(s);
            end
            ecount++;
        end
        check({tag, "_count"},       32'(count),       ecount);
        check({tag, "_best_seed"},   32'(best_seed),   32'(eb_seed));
        check({tag, "_best_result"}, 32'(best_result), 32'(eb_res));
        check({tag, "_requests"},    32'(n_push),      ecount);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},        32'(busy),          0);
        check({tag, "_done"},        32'(done),          0);
        check({tag, "_out_valid"},   32'(bus.out_valid), 0);
        check({tag, "_in_ready"},    32'(bus.in_ready),  0);
        check({tag, "_out0"},        32'(bus.out0),      0);
        check({tag, "_best_seed"},   32'(best_seed),     0);
        check({tag, "_best_result"}, 32'(best_result),   0);
        check({tag, "_count"},       32'(count),         0);
    endtask

    task automatic watch_no_request(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check({tag, "_no_out_valid"}, 32'(seen), 0);
    endtask

    initial begin
        nrst    = 1'b0;
        start   = 1'b0;
        seed_lo = '0;
        seed_hi = '0;

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start   = 1'($urandom_range(0, 1));
            seed_lo = 16'($urandom);
            seed_hi = 16'($urandom);
        end
        @(negedge clk);
        check_all_zero("reset");
        nrst  = 1'b1;
        start = 1'b0;

        // single seed 27
        start_sweep(27, 27);
        wait_done("s27");
        check_result("s27", 27, 27);
        check("s27_best_result_const", 32'(best_result), 32'd111);

        // 1..10 with random ready and latency
        rdy_rand = 1'b1;
        start_sweep(1, 10);
        wait_done("s1_10");
        check_result("s1_10", 1, 10);
        check("s1_10_best_seed_const", 32'(best_seed), 32'd9);

        // backpressure: results held, FIFO fills at 4
        rdy_rand = 1'b0;
        hold     = 1'b1;
        start_sweep(1, 8);
        repeat (20) @(negedge clk);
        check("bp_requests", 32'(n_push), 32'd4);
        check("bp_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        hold = 1'b0;
        wait_done("bp");
        check_result("bp", 1, 8);

        // tie rule with constant results
        const_mode = 1'b1;
        rdy_rand   = 1'b1;
        start_sweep(3, 6);
        wait_done("tie");
        check_result("tie", 3, 6);
        const_mode = 1'b0;

        // empty range
        start_sweep(5, 4);
        check("empty_done_next", 32'(done), 32'd1);
        check("empty_count", 32'(count), 32'd0);
        check("empty_best_seed", 32'(best_seed), 32'd0);
        check("empty_best_result", 32'(best_result), 32'd0);
        watch_no_request("empty", 6);
        check("empty_requests", 32'(n_push), 32'd0);

        // top of the seed range
        start_sweep(65534, 65535);
        wait_done("top");
        check_result("top", 65534, 65535);
        watch_no_request("top", 6);
        check("top_requests_after", 32'(n_push), 32'd2);

        // reset mid-sweep
        hold = 1'b1;
        start_sweep(1, 10);
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        nrst = 1'b1;
        hold = 1'b0;
        start_sweep(1, 10);
        wait_done("after_reset");
        check_result("after_reset", 1, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
